// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the RAM bus controller.
// Strobe encodings match the ram block's rw/memio pins.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam logic RW_WRITE  = 1'b0;
  localparam logic RW_READ   = 1'b1;
  localparam logic MEMIO_ON  = 1'b1;
  localparam logic MEMIO_OFF = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Single-request controller for the 8-bit ram: sequences rw/memio, owns the
// tri-state data bus and returns a one-cycle completion pulse.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WR_HOLD = 1,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw,
  output logic              ram_memio,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int CNT_W = $clog2(max_int(WR_HOLD, RD_WAIT) + 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_HOLD - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);

  generate
    if (WR_HOLD < 1 || RD_WAIT < 1) begin : g_bad_timing
      $error("mem_bus_ctrl: WR_HOLD and RD_WAIT must both be at least 1");
    end
  endgenerate

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_done;
  logic              accept;
  logic              data_oe;

  assign accept   = req_valid && req_ready;
  assign cnt_done = (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SETUP;
      SETUP:   state_nxt = we_q ? WRITE : READ;
      WRITE:   if (cnt_done) state_nxt = IDLE;
      READ:    if (cnt_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The bus is driven only in a write's SETUP and WRITE, both with rw=0,
  // so it can never overlap a cycle where the ram may drive it.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    ram_rw    = RW_READ;
    ram_memio = MEMIO_OFF;
    data_oe   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      SETUP: begin
        ram_rw  = we_q ? RW_WRITE : RW_READ;
        data_oe = we_q;
      end
      WRITE: begin
        ram_rw    = RW_WRITE;
        ram_memio = MEMIO_ON;
        data_oe   = 1'b1;
      end
      READ: begin
        ram_memio = MEMIO_ON;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
      case (state)
        SETUP: cnt <= we_q ? WR_LOAD : RD_LOAD;
        WRITE: begin
          if (cnt_done) rsp_valid <= 1'b1;
          else          cnt       <= cnt - CNT_W'(1);
        end
        READ: begin
          if (cnt_done) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= ram_data;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_addr = addr_q;
  assign ram_data = data_oe ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: default instance plus a RD_WAIT=3/WR_HOLD=2 variant,
// each on its own ram model, checked every cycle against a transaction-level model.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid [2];
  logic       req_we    [2];
  logic [7:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       busy      [2];
  logic [7:0] ram_addr  [2];
  logic       ram_rw    [2];
  logic       ram_memio [2];
  wire  [7:0] ram_data0;
  wire  [7:0] ram_data1;

  mem_bus_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .ram_addr(ram_addr[0]), .ram_rw(ram_rw[0]), .ram_memio(ram_memio[0]),
    .ram_data(ram_data0)
  );

  mem_bus_ctrl #(.WR_HOLD(2), .RD_WAIT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .ram_addr(ram_addr[1]), .ram_rw(ram_rw[1]), .ram_memio(ram_memio[1]),
    .ram_data(ram_data1)
  );

  // Ram models: combinational read while selected for read, write on the edge.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  assign ram_data0 = (ram_memio[0] && ram_rw[0]) ? mem0[ram_addr[0]] : 8'hzz;
  assign ram_data1 = (ram_memio[1] && ram_rw[1]) ? mem1[ram_addr[1]] : 8'hzz;
  always @(posedge clk) begin
    if (ram_memio[0] === 1'b1 && ram_rw[0] === 1'b0) mem0[ram_addr[0]] <= ram_data0;
    if (ram_memio[1] === 1'b1 && ram_rw[1] === 1'b0) mem1[ram_addr[1]] <= ram_data1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic string nm(input int i, input string s);
    return $sformatf("u%0d %s", i, s);
  endfunction

  // Transaction-level model: one op in flight, lasting 1 + N cycles after acceptance.
  int         cyc = 0;
  bit         en = 1'b0;
  int         nw [2] = '{1, 2};
  int         nr [2] = '{1, 3};
  bit         act [2];
  int         e0 [2];
  int         done_at [2] = '{-1, -1};
  bit         m_we [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_wd [2];
  logic [7:0] mm [2][256];
  bit         poison [2][256];
  logic [7:0] exp_rdata [2];
  bit         rd_unk [2];

  // Observed DUT events, used only by the literal checks.
  int ob_acc [2], ob_rsp [2], ob_mcnt [2], ob_rwcnt [2], ob_nacc [2];

  function automatic int lat(input int i);
    return m_we[i] ? nw[i] : nr[i];
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i] === 1'b1) begin
        ob_acc[i] = cyc; ob_mcnt[i] = 0; ob_rwcnt[i] = 0; ob_nacc[i]++;
      end
      if (ram_memio[i] === 1'b1) begin
        ob_mcnt[i]++;
        if (ram_rw[i] === 1'b1) ob_rwcnt[i]++;
      end
      if (rsp_valid[i] === 1'b1) ob_rsp[i] = cyc;

      if (!rst_n) begin
        en = 1'b1;
        if (act[i] && m_we[i]) poison[i][m_addr[i]] = 1'b1;
        act[i] = 1'b0; done_at[i] = -1; exp_rdata[i] = 8'h00; rd_unk[i] = 1'b0;
      end else if (act[i] && cyc == e0[i] + lat(i) + 1) begin
        if (m_we[i]) begin
          mm[i][m_addr[i]] = m_wd[i];
          poison[i][m_addr[i]] = 1'b0;
        end else begin
          exp_rdata[i] = mm[i][m_addr[i]];
          rd_unk[i] = poison[i][m_addr[i]];
        end
        act[i] = 1'b0; done_at[i] = cyc;
      end else if (!act[i] && req_valid[i]) begin
        act[i] = 1'b1; e0[i] = cyc;
        m_we[i] = req_we[i]; m_addr[i] = req_addr[i]; m_wd[i] = req_wdata[i];
      end
    end
  end

  task automatic cmp(input int i, input bit dz, input logic [7:0] d);
    int k;
    k = cyc - e0[i];
    if (act[i]) begin
      check(nm(i, "busy"), busy[i], 1);
      check(nm(i, "req_ready"), req_ready[i], 0);
      check(nm(i, "rsp_valid"), rsp_valid[i], 0);
      check(nm(i, "ram_addr"), ram_addr[i], m_addr[i]);
      check(nm(i, "ram_rw"), ram_rw[i], !m_we[i]);
      check(nm(i, "ram_memio"), ram_memio[i], (k >= 1));
      if (m_we[i])                  check(nm(i, "write data"), d, m_wd[i]);
      else if (k == 0)              check(nm(i, "bus released in read setup"), dz, 1);
      else if (!poison[i][m_addr[i]]) check(nm(i, "read bus data"), d, mm[i][m_addr[i]]);
    end else begin
      check(nm(i, "busy"), busy[i], 0);
      check(nm(i, "req_ready"), req_ready[i], 1);
      check(nm(i, "rsp_valid"), rsp_valid[i], (done_at[i] == cyc));
      check(nm(i, "ram_memio"), ram_memio[i], 0);
      check(nm(i, "ram_rw"), ram_rw[i], 1);
      check(nm(i, "bus released in idle"), dz, 1);
    end
    if (!rd_unk[i]) check(nm(i, "rsp_rdata"), rsp_rdata[i], exp_rdata[i]);
  endtask

  always @(negedge clk) begin
    if (en) begin
      cmp(0, ram_data0 === 8'hzz, ram_data0);
      cmp(1, ram_data1 === 8'hzz, ram_data1);
    end
  end

  // Stimulus tasks are entered and left at a falling edge.
  task automatic do_op(input int i, input bit we, input logic [7:0] a,
                       input logic [7:0] d, input bit hold);
    int c0;
    int t;
    c0 = ob_nacc[i];
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d;
    t = 0;
    while (ob_nacc[i] == c0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check(nm(i, "acceptance count"), ob_nacc[i] - c0, 1);
    if (!hold) req_valid[i] = 1'b0;
    req_we[i] = 1'($urandom); req_addr[i] = 8'($urandom); req_wdata[i] = 8'($urandom);
  endtask

  task automatic wait_idle(input int i);
    int t;
    t = 0;
    while (busy[i] !== 1'b0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check(nm(i, "idle wait"), busy[i], 0);
    @(negedge clk);
  endtask

  int t1, t2, t3, t4, n0;

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00; mem1[i] = 8'h00;
      mm[0][i] = 8'h00; mm[1][i] = 8'h00;
    end
    mem0[8'h20] = 8'h3C; mem1[8'h20] = 8'h3C;
    mm[0][8'h20] = 8'h3C; mm[1][8'h20] = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 8'h00; req_wdata[i] = 8'h00;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset req_ready", req_ready[0], 1);
    check("reset busy", busy[0], 0);
    check("reset rsp_valid", rsp_valid[0], 0);
    check("reset rsp_rdata", rsp_rdata[0], 8'h00);
    check("reset ram_addr", ram_addr[0], 8'h00);
    check("reset ram_rw", ram_rw[0], 1);
    check("reset ram_memio", ram_memio[0], 0);
    check("reset bus released", ram_data0 === 8'hzz, 1);

    // Write 0xA9 @ 0x01 then read it back.
    do_op(0, 1'b1, 8'h01, 8'hA9, 1'b0);
    wait_idle(0);
    check("write latency", ob_rsp[0] - ob_acc[0], 3);
    check("write memio cycles", ob_mcnt[0], 1);
    check("write strobe rw", ob_rwcnt[0], 0);
    do_op(0, 1'b0, 8'h01, 8'h00, 1'b0);
    wait_idle(0);
    check("read latency", ob_rsp[0] - ob_acc[0], 3);
    check("read strobe rw", ob_rwcnt[0], 1);
    check("read 0x01", rsp_rdata[0], 8'hA9);

    // Reset held for two edges during the WRITE cycle of 0x55 @ 0x10.
    do_op(0, 1'b1, 8'h10, 8'h55, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset memio", ram_memio[0], 0);
    check("mid reset bus released", ram_data0 === 8'hzz, 1);
    check("mid reset rsp_valid", rsp_valid[0], 0);
    check("mid reset req_ready", req_ready[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 1'b0, 8'h20, 8'h00, 1'b0);
    wait_idle(0);
    check("read 0x20 after reset", rsp_rdata[0], 8'h3C);

    // Back-to-back with req_valid held high throughout.
    do_op(0, 1'b1, 8'h02, 8'h11, 1'b1); t1 = ob_acc[0];
    do_op(0, 1'b1, 8'h03, 8'h22, 1'b1); t2 = ob_acc[0];
    do_op(0, 1'b0, 8'h02, 8'h00, 1'b1); t3 = ob_acc[0];
    do_op(0, 1'b0, 8'h03, 8'h00, 1'b0); t4 = ob_acc[0];
    check("b2b spacing 1", t2 - t1, 3);
    check("b2b spacing 2", t3 - t2, 3);
    check("b2b spacing 3", t4 - t3, 3);
    check("b2b read 0x02", rsp_rdata[0], 8'h11);
    wait_idle(0);
    check("b2b read 0x03", rsp_rdata[0], 8'h22);

    // Request pulsed while busy must be dropped.
    do_op(0, 1'b1, 8'h06, 8'h77, 1'b0);
    n0 = ob_nacc[0];
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h05; req_wdata[0] = 8'hFF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_idle(0);
    check("busy request ignored", ob_nacc[0] - n0, 0);
    do_op(0, 1'b0, 8'h05, 8'h00, 1'b0);
    wait_idle(0);
    check("read 0x05 untouched", rsp_rdata[0], 8'h00);

    // Slow variant.
    do_op(1, 1'b1, 8'hFE, 8'hC3, 1'b0);
    wait_idle(1);
    check("u1 write latency", ob_rsp[1] - ob_acc[1], 4);
    check("u1 write memio cycles", ob_mcnt[1], 2);
    do_op(1, 1'b0, 8'hFE, 8'h00, 1'b0);
    wait_idle(1);
    check("u1 read latency", ob_rsp[1] - ob_acc[1], 5);
    check("u1 read memio cycles", ob_mcnt[1], 3);
    check("u1 read 0xFE", rsp_rdata[1], 8'hC3);

    // Random mix; the per-cycle compare covers timing, strobes and bus ownership.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_op(0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom_range(0, 1)));
    end
    req_valid[0] = 1'b0;
    wait_idle(0);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_op(1, 1'($urandom), 8'($urandom_range(240, 255)), 8'($urandom),
            1'($urandom_range(0, 1)));
    end
    req_valid[1] = 1'b0;
    wait_idle(1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
